// File: rtl/hit_window_pkg.sv
// Shared types and helpers for the hit window accumulator.
package hit_window_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2,
        DEAD  = 2'd3
    } state_t;

    function automatic int num_groups(input int data_width, input int group_width);
        return data_width / group_width;
    endfunction

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
        logic [63:0] top;
        top = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value == top) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/hit_group_or.sv
// Reduces an accumulated hit word to per-group OR flags plus the word's msb.
module hit_group_or #(
    parameter int DATA_WIDTH  = 66,
    parameter int GROUP_WIDTH = 16,
    parameter int NUM_GROUPS  = 4
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic [NUM_GROUPS:0]   test
);

    // Tail bits past the last whole group only reach the msb flag.
    logic unused_tail;
    assign unused_tail = ^data;

    always_comb begin
        test = '0;
        for (int i = 0; i < NUM_GROUPS; i++) begin
            test[i] = |data[i*GROUP_WIDTH +: GROUP_WIDTH];
        end
        test[NUM_GROUPS] = data[DATA_WIDTH-1];
    end

endmodule

// File: rtl/hit_window_accumulator.sv
// Arms on a masked hit, ORs din over a latched window and emits the word on AXI4-Stream.
// Optional DEADTIME_EN adds a programmable dead period after each accepted word.
module hit_window_accumulator
    import hit_window_pkg::*;
#(
    parameter int  DATA_WIDTH  = 66,
    parameter int  GROUP_WIDTH = 16,
    parameter int  CNTR_WIDTH  = 8,
    parameter int  STAT_WIDTH  = 32,
    localparam int NUM_GROUPS  = num_groups(DATA_WIDTH, GROUP_WIDTH)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] cfg_mask,
    input  logic [CNTR_WIDTH-1:0] cfg_window,
    input  logic [CNTR_WIDTH-1:0] cfg_deadtime,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [NUM_GROUPS:0]   test,
    output logic                  busy,
    output logic [STAT_WIDTH-1:0] event_cnt,
    output logic [STAT_WIDTH-1:0] drop_cnt
);

    state_t                state;
    logic [DATA_WIDTH-1:0] data;
    logic [CNTR_WIDTH-1:0] cntr;
    logic [CNTR_WIDTH-1:0] win_lat;
    logic [DATA_WIDTH-1:0] acc_word;
    logic [NUM_GROUPS:0]   group_flags;
    logic                  trig;

`ifdef DEADTIME_EN
    logic [CNTR_WIDTH-1:0] dead_lat;
`else
    logic unused_deadtime;
    assign unused_deadtime = ^cfg_deadtime;
`endif

    assign trig         = |(din & cfg_mask);
    assign acc_word     = data | din;
    assign m_axis_tdata = data;
    assign busy         = (state != IDLE);

    // Flags are computed on the word being closed so they register with the ACCUM->OUT step.
    hit_group_or #(
        .DATA_WIDTH  (DATA_WIDTH),
        .GROUP_WIDTH (GROUP_WIDTH),
        .NUM_GROUPS  (NUM_GROUPS)
    ) u_group_or (
        .data (acc_word),
        .test (group_flags)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            data          <= '0;
            cntr          <= '0;
            win_lat       <= '0;
            m_axis_tvalid <= 1'b0;
            test          <= '0;
            event_cnt     <= '0;
`ifdef DEADTIME_EN
            dead_lat      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    data <= din;
                    cntr <= '0;
                    if (trig) begin
                        win_lat <= cfg_window;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    data <= acc_word;
                    cntr <= cntr + 1'b1;
                    if (cntr >= win_lat) begin
                        state         <= OUT;
                        m_axis_tvalid <= 1'b1;
                        test          <= group_flags;
                    end
                end
                OUT: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        event_cnt     <= STAT_WIDTH'(sat_inc(64'(event_cnt), STAT_WIDTH));
                        cntr          <= '0;
`ifdef DEADTIME_EN
                        if (cfg_deadtime != '0) begin
                            dead_lat <= cfg_deadtime;
                            state    <= DEAD;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
                DEAD: begin
`ifdef DEADTIME_EN
                    if (cntr >= dead_lat - 1'b1) begin
                        cntr  <= '0;
                        state <= IDLE;
                    end else begin
                        cntr <= cntr + 1'b1;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Triggers that arrive while a word is pending or during dead time are lost.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            drop_cnt <= '0;
        end else if (((state == OUT) || (state == DEAD)) && trig) begin
            drop_cnt <= STAT_WIDTH'(sat_inc(64'(drop_cnt), STAT_WIDTH));
        end
    end

endmodule

// File: tb/tb_hit_window_accumulator.sv
// Scoreboard bench for hit_window_accumulator; expected words queued at stimulus time.
module tb_hit_window_accumulator;

    localparam int DW  = 66;
    localparam int GW  = 16;
    localparam int CW  = 8;
    localparam int SW  = 5;
    localparam int NG  = DW / GW;
    localparam int SAT = (1 << SW) - 1;
`ifdef DEADTIME_EN
    localparam int DEFF = 5;
`else
    localparam int DEFF = 0;
`endif

    logic          aclk = 1'b0;
    logic          areset;
    logic [DW-1:0] din;
    logic [DW-1:0] cfg_mask;
    logic [CW-1:0] cfg_window;
    logic [CW-1:0] cfg_deadtime;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [NG:0]   test;
    logic          busy;
    logic [SW-1:0] event_cnt;
    logic [SW-1:0] drop_cnt;

    logic [DW-1:0] exp_q[$];
    int            hs_cyc[$];
    int            cyc = 0;
    int            n_words = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            exp_ev = 0;
    int            exp_drop = 0;

    hit_window_accumulator #(
        .DATA_WIDTH  (DW),
        .GROUP_WIDTH (GW),
        .CNTR_WIDTH  (CW),
        .STAT_WIDTH  (SW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .din           (din),
        .cfg_mask      (cfg_mask),
        .cfg_window    (cfg_window),
        .cfg_deadtime  (cfg_deadtime),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .test          (test),
        .busy          (busy),
        .event_cnt     (event_cnt),
        .drop_cnt      (drop_cnt)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // Output monitor: every accepted word must match the oldest expected word.
    always @(negedge aclk) begin
        if (!areset && m_axis_tvalid && m_axis_tready) begin
            n_checks++;
            n_words++;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL word_unexpected: got %h, required no word", m_axis_tdata);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (m_axis_tdata !== e) begin
                    n_fail++;
                    $display("FAIL word_data: got %h, required %h", m_axis_tdata, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input logic [DW-1:0] v);
        din = v;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset;
        areset = 1'b1;
        din = '0;
        cfg_mask = '1;
        cfg_window = 8'd3;
        cfg_deadtime = 8'd0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0) begin
            n_fail++;
            $display("FAIL reset_axis: got tvalid=%b tdata=%h, required 0/0", m_axis_tvalid, m_axis_tdata);
        end
        n_checks++;
        if (test !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got test=%b busy=%b, required 0/0", test, busy);
        end
        n_checks++;
        if (event_cnt !== '0 || drop_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_counters: got ev=%0d drop=%0d, required 0/0", event_cnt, drop_cnt);
        end
        areset = 1'b0;
        tick('0);
    endtask

    task automatic test_basic_window;
        cfg_mask = '1;
        cfg_window = 8'd3;
        m_axis_tready = 1'b1;
        exp_q.push_back(66'h10001);
        tick(66'h1);
        cfg_window = 8'd0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b, required 1", busy);
        end
        tick('0);
        tick(66'h10000);
        tick('0);
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early_valid: got %b, required 0", m_axis_tvalid);
        end
        tick('0);
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 66'h10001) begin
            n_fail++;
            $display("FAIL basic_out: got tvalid=%b tdata=%h, required 1/10001", m_axis_tvalid, m_axis_tdata);
        end
        n_checks++;
        if (test !== 5'b00011) begin
            n_fail++;
            $display("FAIL basic_test: got %b, required 00011", test);
        end
        tick(66'h2);
        exp_ev++;
        exp_drop++;
        n_checks++;
        if (event_cnt !== SW'(exp_ev) || drop_cnt !== SW'(exp_drop) || m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_counts: got ev=%0d drop=%0d tvalid=%b, required %0d/%0d/0",
                     event_cnt, drop_cnt, m_axis_tvalid, exp_ev, exp_drop);
        end
    endtask

    task automatic test_zero_window;
        cfg_window = 8'd0;
        exp_q.push_back(66'h2_0000_0000_0000_0103);
        tick(66'h3);
        tick(66'h2_0000_0000_0000_0100);
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 66'h2_0000_0000_0000_0103) begin
            n_fail++;
            $display("FAIL w0_out: got tvalid=%b tdata=%h, required 1/20000000000000103", m_axis_tvalid, m_axis_tdata);
        end
        n_checks++;
        if (test !== 5'b10001) begin
            n_fail++;
            $display("FAIL w0_test_msb: got %b, required 10001", test);
        end
        tick('0);
        exp_ev++;
        n_checks++;
        if (event_cnt !== SW'(exp_ev)) begin
            n_fail++;
            $display("FAIL w0_event: got %0d, required %0d", event_cnt, exp_ev);
        end
    endtask

    task automatic test_mask;
        cfg_mask = 66'hFFFF;
        cfg_window = 8'd1;
        repeat (3) tick(66'h10000);
        n_checks++;
        if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_no_trigger: got busy=%b tvalid=%b, required 0/0", busy, m_axis_tvalid);
        end
        exp_q.push_back(66'h10001);
        tick(66'h1);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mask_trigger: got busy=%b, required 1", busy);
        end
        tick(66'h10000);
        tick('0);
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || test !== 5'b00011) begin
            n_fail++;
            $display("FAIL mask_out: got tvalid=%b test=%b, required 1/00011", m_axis_tvalid, test);
        end
        tick(66'h10000);
        exp_ev++;
        n_checks++;
        if (drop_cnt !== SW'(exp_drop) || event_cnt !== SW'(exp_ev)) begin
            n_fail++;
            $display("FAIL mask_counts: got drop=%0d ev=%0d, required %0d/%0d", drop_cnt, event_cnt, exp_drop, exp_ev);
        end
    endtask

    task automatic test_backpressure;
        int words_before;
        cfg_mask = '1;
        cfg_window = 8'd2;
        m_axis_tready = 1'b0;
        words_before = n_words;
        exp_q.push_back(66'h25);
        tick(66'h5);
        tick('0);
        tick(66'h20);
        tick('0);
        for (int i = 0; i < 10; i++) begin
            tick((i % 3 == 0) ? 66'h8 : 66'h0);
            n_checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 66'h25) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got tvalid=%b tdata=%h, required 1/25", i, m_axis_tvalid, m_axis_tdata);
            end
        end
        m_axis_tready = 1'b1;
        tick('0);
        exp_drop += 4;
        exp_ev++;
        n_checks++;
        if (drop_cnt !== SW'(exp_drop) || event_cnt !== SW'(exp_ev) || m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_counts: got drop=%0d ev=%0d tvalid=%b, required %0d/%0d/0",
                     drop_cnt, event_cnt, m_axis_tvalid, exp_drop, exp_ev);
        end
        n_checks++;
        if (n_words - words_before !== 1) begin
            n_fail++;
            $display("FAIL bp_word_count: got %0d, required 1", n_words - words_before);
        end
    endtask

    task automatic test_back_to_back;
        localparam int K = 3;
        int period;
        int base;
        cfg_mask = '1;
        cfg_window = 8'd2;
        cfg_deadtime = 8'd5;
        m_axis_tready = 1'b1;
        period = 2 + 3 + DEFF;
        base = hs_cyc.size();
        for (int k = 0; k < K; k++) exp_q.push_back(66'h1);
        for (int i = 0; i <= (K - 1) * period; i++) tick(66'h1);
        for (int i = 0; i < 20 && hs_cyc.size() < base + K; i++) tick('0);
        n_checks++;
        if (hs_cyc.size() - base !== K) begin
            n_fail++;
            $display("FAIL b2b_words: got %0d, required %0d", hs_cyc.size() - base, K);
        end else begin
            for (int k = 1; k < K; k++) begin
                n_checks++;
                if (hs_cyc[base + k] - hs_cyc[base + k - 1] !== period) begin
                    n_fail++;
                    $display("FAIL b2b_spacing[%0d]: got %0d, required %0d", k,
                             hs_cyc[base + k] - hs_cyc[base + k - 1], period);
                end
            end
        end
        repeat (8) tick('0);
        exp_ev += K;
        exp_drop += (K - 1) * (DEFF + 1);
        n_checks++;
        if (drop_cnt !== SW'(exp_drop) || event_cnt !== SW'(exp_ev) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_counts: got drop=%0d ev=%0d busy=%b, required %0d/%0d/0",
                     drop_cnt, event_cnt, busy, exp_drop, exp_ev);
        end
        cfg_deadtime = 8'd0;
    endtask

    task automatic test_saturation;
        int target;
        cfg_window = 8'd0;
        cfg_deadtime = 8'd0;
        m_axis_tready = 1'b0;
        exp_q.push_back(66'h1);
        tick(66'h1);
        tick('0);
        repeat (40) tick(66'h1);
        exp_drop = SAT;
        n_checks++;
        if (drop_cnt !== SW'(exp_drop)) begin
            n_fail++;
            $display("FAIL sat_drop: got %0d, required %0d", drop_cnt, exp_drop);
        end
        m_axis_tready = 1'b1;
        tick('0);
        exp_ev++;
        target = n_words + 30;
        for (int k = 0; k < 30; k++) exp_q.push_back(66'h1);
        for (int i = 0; i <= 29 * 3; i++) tick(66'h1);
        for (int i = 0; i < 20 && n_words < target; i++) tick('0);
        exp_ev += 30;
        if (exp_ev > SAT) exp_ev = SAT;
        n_checks++;
        if (event_cnt !== SW'(exp_ev) || drop_cnt !== SW'(exp_drop)) begin
            n_fail++;
            $display("FAIL sat_event: got ev=%0d drop=%0d, required %0d/%0d", event_cnt, drop_cnt, exp_ev, exp_drop);
        end
    endtask

    task automatic test_reset_mid;
        cfg_window = 8'd5;
        m_axis_tready = 1'b1;
        tick(66'h1);
        tick(66'h40);
        areset = 1'b1;
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || event_cnt !== '0 || drop_cnt !== '0 || m_axis_tdata !== '0) begin
            n_fail++;
            $display("FAIL rst_accum: got tvalid=%b busy=%b ev=%0d drop=%0d tdata=%h, required all 0",
                     m_axis_tvalid, busy, event_cnt, drop_cnt, m_axis_tdata);
        end
        @(posedge aclk);
        #1;
        areset = 1'b0;
        exp_ev = 0;
        exp_drop = 0;
        cfg_window = 8'd1;
        exp_q.push_back(66'h7);
        tick(66'h3);
        tick(66'h4);
        tick('0);
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 66'h7) begin
            n_fail++;
            $display("FAIL rst_fresh_out: got tvalid=%b tdata=%h, required 1/7", m_axis_tvalid, m_axis_tdata);
        end
        tick('0);
        exp_ev++;
        n_checks++;
        if (event_cnt !== SW'(exp_ev)) begin
            n_fail++;
            $display("FAIL rst_fresh_event: got %0d, required %0d", event_cnt, exp_ev);
        end
        cfg_window = 8'd0;
        m_axis_tready = 1'b0;
        tick(66'h1);
        tick('0);
        n_checks++;
        if (m_axis_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_out_pre: got tvalid=%b, required 1", m_axis_tvalid);
        end
        areset = 1'b1;
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || event_cnt !== '0) begin
            n_fail++;
            $display("FAIL rst_out: got tvalid=%b ev=%0d, required 0/0", m_axis_tvalid, event_cnt);
        end
        @(posedge aclk);
        #1;
        areset = 1'b0;
        m_axis_tready = 1'b1;
        tick('0);
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_zero_window();
        test_mask();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending words, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
